// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: per-requester request and response channels for the shared alu arbiter
interface alu_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32,
    parameter int OP_W  = 4
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_op;
    logic [N_REQ*XLEN-1:0] req_a;
    logic [N_REQ*XLEN-1:0] req_b;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [XLEN-1:0]       rsp_result;
    logic                  rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational alu, one operation in flight
module alu_arbiter #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32,
    parameter int OP_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_arbiter_if.slave    bus,
    output logic [OP_W-1:0] alu_op,
    output logic [XLEN-1:0] alu_in_a,
    output logic [XLEN-1:0] alu_in_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);
    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_q, last_d, owner_q, owner_d, grant, idx;
    logic [OP_W-1:0] op_q, op_d, op_sel;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, a_sel, b_sel, result_q, result_d;
    logic            zero_q, zero_d, req_acc, rsp_acc;

    // Search descends so the requester nearest after last_q is written last and wins
    always_comb begin
        grant = last_q;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = GW'((int'(last_q) + k) % N_REQ);
            if (bus.req_valid[idx]) grant = idx;
        end
    end

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == GW'(i)) begin
                op_sel = bus.req_op[i*OP_W +: OP_W];
                a_sel  = bus.req_a[i*XLEN +: XLEN];
                b_sel  = bus.req_b[i*XLEN +: XLEN];
            end
        end
    end

    // rst_n gating keeps req_ready low while reset is held
    assign req_acc = rst_n && state_q == IDLE && |bus.req_valid;
    assign rsp_acc = state_q == RESP && bus.rsp_ready[owner_q];

    always_comb begin
        state_d = state_q == IDLE ? (req_acc ? EXEC : IDLE) :
                  state_q == EXEC ? RESP : (rsp_acc ? IDLE : RESP);
    end

    always_comb begin
        op_d     = req_acc ? op_sel : op_q;
        a_d      = req_acc ? a_sel : a_q;
        b_d      = req_acc ? b_sel : b_q;
        last_d   = req_acc ? grant : last_q;
        owner_d  = req_acc ? grant : owner_q;
        result_d = state_q == EXEC ? alu_result : result_q;
        zero_d   = state_q == EXEC ? alu_zero : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= GW'(N_REQ - 1);
            owner_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        bus.req_ready  = req_acc ? N_REQ'(1) << grant : '0;
        bus.rsp_valid  = state_q == RESP ? N_REQ'(1) << owner_q : '0;
        bus.rsp_result = result_q;
        bus.rsp_zero   = zero_q;
        alu_op         = op_q;
        alu_in_a       = a_q;
        alu_in_b       = b_q;
    end

    a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.rsp_valid));
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid != '0 && !rsp_acc) |=> $stable(bus.rsp_result) && $stable(bus.rsp_zero));
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        state_q != IDLE |-> bus.req_ready == '0);

    for (genvar g = 0; g < N_REQ; g++) begin : g_req_chk
        a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (bus.req_valid[g] && !bus.req_ready[g]) |=> !bus.req_valid[g] ||
            ($stable(bus.req_op[g*OP_W +: OP_W]) && $stable(bus.req_a[g*XLEN +: XLEN]) &&
             $stable(bus.req_b[g*XLEN +: XLEN])));
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with per-requester expected-response queues checked by a monitor
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3, OP_BAD = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_a, alu_in_b, alu_result;
    logic        alu_zero;
    int          total = 0;
    int          bad = 0;
    logic [32:0] exp0[$], exp1[$];
    int          glog[$];

    alu_arbiter_if #(.N_REQ(2), .XLEN(32), .OP_W(4)) bus();

    alu_arbiter #(.N_REQ(2), .XLEN(32), .OP_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_in_a, alu_in_b);
    assign alu_zero   = alu_result == 32'h0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: responses are checked on the half cycle before their accepting edge
    always @(negedge clk) begin
        if (rst_n) begin
            if ((bus.req_valid & bus.req_ready) != 2'b00) glog.push_back(bus.req_ready[1] ? 1 : 0);
            if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
                if (exp0.size() == 0) flag("rsp0_unexpected");
                else chk("rsp0", {bus.rsp_zero, bus.rsp_result}, exp0.pop_front());
            end
            if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
                if (exp1.size() == 0) flag("rsp1_unexpected");
                else chk("rsp1", {bus.rsp_zero, bus.rsp_result}, exp1.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[i*4 +: 4]  = op;
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    // Returns #1 after the accepting edge with the requester's valid dropped
    task automatic wait_hs(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.req_valid[i] && bus.req_ready[i]) && n < 60);
        if (!(bus.req_valid[i] && bus.req_ready[i])) flag($sformatf("hs%0d_timeout", i));
        @(posedge clk);
        #1 bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        chk("drain_left", 64'(exp0.size() + exp1.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  drop;
        logic [3:0]  gs;
        logic [31:0] ra, rb, e;
        int          hs0, hs1, n;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        #12;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp", {bus.rsp_zero, bus.rsp_result}, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_in_a, 0);
        chk("rst_alu_b", alu_in_b, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single add, latency
        bus.rsp_ready = 2'b11;
        set_req(0, OP_ADD, 32'h5, 32'h3);
        exp0.push_back({1'b0, 32'h8});
        bus.req_valid[0] = 1'b1;
        #1 chk("t1_ready_same_cycle", bus.req_ready, 2'b01);
        wait_hs(0);
        chk("t1_exec_rsp_valid", bus.rsp_valid, 2'b00);
        chk("t1_alu_op", alu_op, OP_ADD);
        @(posedge clk);
        #1 chk("t1_rsp_valid", bus.rsp_valid, 2'b01);
        drain();

        // Alternation with both requesters valid
        do_reset();
        bus.rsp_ready = 2'b11;
        set_req(0, OP_SUB, 32'h7, 32'h7);
        set_req(1, OP_OR, 32'hF0, 32'h0F);
        repeat (2) begin
            exp0.push_back({1'b1, 32'h0});
            exp1.push_back({1'b0, 32'hFF});
        end
        glog.delete();
        bus.req_valid = 2'b11;
        hs0 = 0;
        hs1 = 0;
        n = 0;
        while ((hs0 < 2 || hs1 < 2) && n < 80) begin
            @(negedge clk);
            n++;
            drop = 2'b00;
            if (bus.req_valid[0] && bus.req_ready[0]) begin hs0++; if (hs0 == 2) drop[0] = 1'b1; end
            if (bus.req_valid[1] && bus.req_ready[1]) begin hs1++; if (hs1 == 2) drop[1] = 1'b1; end
            @(posedge clk);
            #1 bus.req_valid = bus.req_valid & ~drop;
        end
        drain();
        chk("t2_grant_count", 64'(glog.size()), 64'd4);
        gs = 4'b0000;
        for (int k = 0; k < glog.size() && k < 4; k++) gs[3-k] = glog[k] == 1;
        chk("t2_grant_order", gs, 4'b0101);

        // Back-pressure on requester 0 while requester 1 waits
        bus.rsp_ready = 2'b00;
        set_req(0, OP_AND, 32'hFFFF_0000, 32'h0FF0_0FF0);
        exp0.push_back({1'b0, 32'h0FF0_0000});
        exp1.push_back({1'b0, 32'hFF});
        bus.req_valid = 2'b11;
        wait_hs(0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", bus.rsp_valid, 2'b01);
            chk("t3_hold_result", bus.rsp_result, 32'h0FF0_0000);
            chk("t3_hold_no_ready", bus.req_ready, 2'b00);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 2'b01;
        #1 chk("t3_no_ready_at_accept", bus.req_ready, 2'b00);
        @(posedge clk);
        #1 chk("t3_req1_ready_after", bus.req_ready, 2'b10);
        bus.rsp_ready = 2'b11;
        wait_hs(1);
        drain();

        // Wrap-around to zero
        set_req(0, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        exp0.push_back({1'b1, 32'h0});
        bus.req_valid[0] = 1'b1;
        wait_hs(0);
        drain();

        // Illegal op forwarded untouched
        ra = $urandom;
        rb = $urandom;
        set_req(0, OP_BAD, ra, rb);
        e = ~(ra & rb);
        exp0.push_back({e == 32'h0, e});
        bus.req_valid[0] = 1'b1;
        wait_hs(0);
        chk("t5_alu_op", alu_op, OP_BAD);
        chk("t5_alu_a", alu_in_a, ra);
        chk("t5_alu_b", alu_in_b, rb);
        drain();

        // Asynchronous reset while requester 1 holds a response
        bus.rsp_ready = 2'b00;
        set_req(1, OP_OR, 32'hF0, 32'h0F);
        bus.req_valid[1] = 1'b1;
        wait_hs(1);
        @(posedge clk);
        #1 chk("t6_rsp_valid", bus.rsp_valid, 2'b10);
        set_req(0, OP_ADD, 32'h5, 32'h3);
        bus.req_valid = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("t6_rst_req_ready", bus.req_ready, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("t6_first_grant", bus.req_ready, 2'b01);
        bus.rsp_ready = 2'b11;
        exp0.push_back({1'b0, 32'h8});
        exp1.push_back({1'b0, 32'hFF});
        wait_hs(0);
        wait_hs(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
